// File: rtl/keypad_input.sv
// 4x5 key matrix scanner: synchronises, debounces and encodes one key press
// into an input-interface command that is held until the controller acknowledges it.

package keypad_input_pkg;
    localparam int unsigned IC_N = 5;

    localparam logic [IC_N-1:0] IC_NONE = 5'd0;
    localparam logic [IC_N-1:0] IC_NUM0 = 5'd1;
    localparam logic [IC_N-1:0] IC_NUM1 = 5'd2;
    localparam logic [IC_N-1:0] IC_NUM2 = 5'd3;
    localparam logic [IC_N-1:0] IC_NUM3 = 5'd4;
    localparam logic [IC_N-1:0] IC_NUM4 = 5'd5;
    localparam logic [IC_N-1:0] IC_NUM5 = 5'd6;
    localparam logic [IC_N-1:0] IC_NUM6 = 5'd7;
    localparam logic [IC_N-1:0] IC_NUM7 = 5'd8;
    localparam logic [IC_N-1:0] IC_NUM8 = 5'd9;
    localparam logic [IC_N-1:0] IC_NUM9 = 5'd10;
    localparam logic [IC_N-1:0] IC_EXAD = 5'd11;
    localparam logic [IC_N-1:0] IC_EXSB = 5'd12;
    localparam logic [IC_N-1:0] IC_EXMU = 5'd13;
    localparam logic [IC_N-1:0] IC_EXDI = 5'd14;
    localparam logic [IC_N-1:0] IC_EXOK = 5'd15;
    localparam logic [IC_N-1:0] IC_EXLP = 5'd16;
    localparam logic [IC_N-1:0] IC_EXRP = 5'd17;
    localparam logic [IC_N-1:0] IC_CLBK = 5'd18;
    localparam logic [IC_N-1:0] IC_CLCL = 5'd19;
endpackage

module keypad_input
    import keypad_input_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 64,
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [3:0]      kp_row,
    output logic [4:0]      kp_col,
    output logic [IC_N-1:0] in_cmd,
    input  logic            in_ack
);

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 5;
    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEB_FRAMES + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    logic [ROWS-1:0]   r_row_meta;
    logic [ROWS-1:0]   r_row_sync;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [2:0]        r_col;
    logic [COLS-1:0]   r_kp_col;

    logic [1:0]        r_hits;
    logic [1:0]        r_hit_row;
    logic [2:0]        r_hit_col;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cand_row;
    logic [2:0]        r_cand_col;
    logic [1:0]        w_cand_row_nxt;
    logic [2:0]        w_cand_col_nxt;
    logic [DEB_W-1:0]  r_frm_cnt;
    logic [DEB_W-1:0]  w_frm_cnt_nxt;
    logic [IC_N-1:0]   r_in_cmd;
    logic [IC_N-1:0]   w_in_cmd_nxt;

    logic              w_sample_end;
    logic              w_frame_end;
    logic [ROWS-1:0]   w_row_low;
    logic [1:0]        w_slot_hits;
    logic [1:0]        w_slot_row;
    logic [2:0]        w_hit_sum;
    logic [1:0]        w_tot_hits;
    logic [1:0]        w_key_row;
    logic [2:0]        w_key_col;
    logic              w_frame_key;
    logic              w_frame_none;

    assign kp_col = r_kp_col;
    assign in_cmd = r_in_cmd;

    function automatic logic [IC_N-1:0] key_code(input logic [1:0] row, input logic [2:0] col);
        logic [IC_N-1:0] code;
        case ({row, col})
            {2'd0, 3'd0}: code = IC_NUM7;
            {2'd0, 3'd1}: code = IC_NUM8;
            {2'd0, 3'd2}: code = IC_NUM9;
            {2'd0, 3'd3}: code = IC_EXDI;
            {2'd0, 3'd4}: code = IC_CLBK;
            {2'd1, 3'd0}: code = IC_NUM4;
            {2'd1, 3'd1}: code = IC_NUM5;
            {2'd1, 3'd2}: code = IC_NUM6;
            {2'd1, 3'd3}: code = IC_EXMU;
            {2'd1, 3'd4}: code = IC_CLCL;
            {2'd2, 3'd0}: code = IC_NUM1;
            {2'd2, 3'd1}: code = IC_NUM2;
            {2'd2, 3'd2}: code = IC_NUM3;
            {2'd2, 3'd3}: code = IC_EXSB;
            {2'd2, 3'd4}: code = IC_EXLP;
            {2'd3, 3'd0}: code = IC_NUM0;
            {2'd3, 3'd1}: code = IC_EXOK;
            {2'd3, 3'd2}: code = IC_EXAD;
            {2'd3, 3'd3}: code = IC_EXRP;
            default:      code = IC_NONE;
        endcase
        return code;
    endfunction

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= kp_row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_sample_end = (r_slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign w_frame_end  = w_sample_end && (r_col == 3'd4);

    // Column slot timer and one-cold column drive
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_slot_cnt <= '0;
            r_col      <= 3'd0;
            r_kp_col   <= 5'b11110;
        end else if (w_sample_end) begin
            r_slot_cnt <= '0;
            r_col      <= (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
            r_kp_col   <= {r_kp_col[3:0], r_kp_col[4]};
        end else begin
            r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
        end
    end

    // Row hits in the current slot; the unused r3c4 position is masked out
    always_comb begin
        w_row_low   = ~r_row_sync;
        w_slot_hits = 2'd0;
        w_slot_row  = 2'd0;
        if (r_col == 3'd4) begin
            w_row_low[3] = 1'b0;
        end
        for (int i = 0; i < ROWS; i++) begin
            if (w_row_low[i]) begin
                w_slot_row = 2'(i);
                if (w_slot_hits != 2'd2) begin
                    w_slot_hits = w_slot_hits + 2'd1;
                end
            end
        end
    end

    assign w_hit_sum    = 3'(r_hits) + 3'(w_slot_hits);
    assign w_tot_hits   = (w_hit_sum > 3'd2) ? 2'd2 : w_hit_sum[1:0];
    assign w_key_row    = (r_hits != 2'd0) ? r_hit_row : w_slot_row;
    assign w_key_col    = (r_hits != 2'd0) ? r_hit_col : r_col;
    assign w_frame_key  = w_frame_end && (w_tot_hits == 2'd1);
    assign w_frame_none = w_frame_end && (w_tot_hits == 2'd0);

    // Frame capture: saturating hit count plus the position of the first hit
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_hits    <= 2'd0;
            r_hit_row <= 2'd0;
            r_hit_col <= 3'd0;
        end else if (w_frame_end) begin
            r_hits    <= 2'd0;
            r_hit_row <= 2'd0;
            r_hit_col <= 3'd0;
        end else if (w_sample_end) begin
            r_hits    <= w_tot_hits;
            r_hit_row <= w_key_row;
            r_hit_col <= w_key_col;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= SCAN;
            r_cand_row <= 2'd0;
            r_cand_col <= 3'd0;
            r_frm_cnt  <= '0;
            r_in_cmd   <= IC_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cand_row <= w_cand_row_nxt;
            r_cand_col <= w_cand_col_nxt;
            r_frm_cnt  <= w_frm_cnt_nxt;
            r_in_cmd   <= w_in_cmd_nxt;
        end
    end

    // Acceptance FSM; r_frm_cnt counts matching frames, then release frames
    always_comb begin
        w_state_nxt    = r_state;
        w_cand_row_nxt = r_cand_row;
        w_cand_col_nxt = r_cand_col;
        w_frm_cnt_nxt  = r_frm_cnt;
        w_in_cmd_nxt   = r_in_cmd;
        case (r_state)
            SCAN: begin
                if (w_frame_key) begin
                    w_cand_row_nxt = w_key_row;
                    w_cand_col_nxt = w_key_col;
                    w_frm_cnt_nxt  = DEB_W'(1);
                    if (DEB_FRAMES == 1) begin
                        w_state_nxt  = HOLD;
                        w_in_cmd_nxt = key_code(w_key_row, w_key_col);
                    end else begin
                        w_state_nxt = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (w_frame_end) begin
                    if (w_frame_key && (w_key_row == r_cand_row) && (w_key_col == r_cand_col)) begin
                        w_frm_cnt_nxt = r_frm_cnt + DEB_W'(1);
                        if (r_frm_cnt == DEB_W'(DEB_FRAMES - 1)) begin
                            w_state_nxt  = HOLD;
                            w_in_cmd_nxt = key_code(r_cand_row, r_cand_col);
                        end
                    end else begin
                        w_state_nxt   = SCAN;
                        w_frm_cnt_nxt = '0;
                    end
                end
            end
            HOLD: begin
                if (in_ack) begin
                    w_state_nxt   = WAIT_REL;
                    w_in_cmd_nxt  = IC_NONE;
                    w_frm_cnt_nxt = '0;
                end
            end
            WAIT_REL: begin
                if (w_frame_end) begin
                    if (w_frame_none) begin
                        if (r_frm_cnt == DEB_W'(DEB_FRAMES - 1)) begin
                            w_state_nxt   = SCAN;
                            w_frm_cnt_nxt = '0;
                        end else begin
                            w_frm_cnt_nxt = r_frm_cnt + DEB_W'(1);
                        end
                    end else begin
                        w_frm_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_input.sv
// Directed bench for keypad_input: models the key matrix and checks codes, timing and reset.

module tb_keypad_input;
    import keypad_input_pkg::*;

    logic            Clock;
    logic            Reset;
    logic [3:0]      kp_row;
    logic [4:0]      kp_col;
    logic [IC_N-1:0] in_cmd;
    logic            in_ack;
    logic [19:0]     keys;

    int n_checks;
    int n_pass;

    keypad_input #(.SCAN_DIV(4), .DEB_FRAMES(2)) u_dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .kp_row (kp_row),
        .kp_col (kp_col),
        .in_cmd (in_cmd),
        .in_ack (in_ack)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Key matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        kp_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (keys[r*5+c] && !kp_col[c]) begin
                    kp_row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Return #1 after the edge where column 0 starts a new frame
    task automatic align_frame();
        logic [4:0] prev;
        logic       found;
        prev  = kp_col;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge Clock);
            #1;
            if (kp_col == 5'b11110 && prev == 5'b01111) begin
                found = 1'b1;
            end
            prev = kp_col;
        end
        check("align", 32'(found), 32'd1);
    endtask

    task automatic ack_and_release(input string tag);
        in_ack = 1'b1;
        cycles(1);
        in_ack = 1'b0;
        check(tag, 32'(in_cmd), 32'(IC_NONE));
        keys = '0;
        cycles(60);
    endtask

    initial begin
        logic bad;
        n_checks = 0;
        n_pass   = 0;
        keys     = '0;
        in_ack   = 1'b0;
        Reset    = 1'b0;

        // Reset state and column walk
        #23;
        check("rst_col", 32'(kp_col), 32'h1E);
        check("rst_cmd", 32'(in_cmd), 32'(IC_NONE));
        @(negedge Clock);
        Reset = 1'b1;
        cycles(3);
        check("walk_c0", 32'(kp_col), 32'h1E);
        cycles(1);
        check("walk_c1", 32'(kp_col), 32'h1D);
        cycles(4);
        check("walk_c2", 32'(kp_col), 32'h1B);
        cycles(4);
        check("walk_c3", 32'(kp_col), 32'h17);
        cycles(4);
        check("walk_c4", 32'(kp_col), 32'h0F);
        cycles(4);
        check("walk_wrap", 32'(kp_col), 32'h1E);

        // Steady press r2c1 -> NUM2 after exactly 2 frames
        align_frame();
        keys[11] = 1'b1;
        cycles(39);
        check("num2_early", 32'(in_cmd), 32'(IC_NONE));
        cycles(1);
        check("num2", 32'(in_cmd), 32'(IC_NUM2));
        in_ack = 1'b1;
        cycles(1);
        in_ack = 1'b0;
        check("num2_ack", 32'(in_cmd), 32'(IC_NONE));
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cycles(1);
            if (in_cmd !== IC_NONE) bad = 1'b1;
        end
        check("no_repeat", 32'(bad), 32'd0);
        keys = '0;
        cycles(60);

        // Bounce on r0c4: present, absent, present x2
        align_frame();
        keys[4] = 1'b1;
        cycles(20);
        keys[4] = 1'b0;
        cycles(20);
        keys[4] = 1'b1;
        cycles(39);
        check("clbk_early", 32'(in_cmd), 32'(IC_NONE));
        cycles(1);
        check("clbk", 32'(in_cmd), 32'(IC_CLBK));
        ack_and_release("clbk_ack");

        // Two keys together, then one released
        align_frame();
        keys[5] = 1'b1;
        keys[6] = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (in_cmd !== IC_NONE) bad = 1'b1;
        end
        check("multi_none", 32'(bad), 32'd0);
        keys[6] = 1'b0;
        cycles(39);
        check("num4_early", 32'(in_cmd), 32'(IC_NONE));
        cycles(1);
        check("num4", 32'(in_cmd), 32'(IC_NUM4));
        ack_and_release("num4_ack");

        // Held code stays stable without ack, then release gating
        align_frame();
        keys[16] = 1'b1;
        cycles(40);
        check("exok", 32'(in_cmd), 32'(IC_EXOK));
        keys = '0;
        bad  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (in_cmd !== IC_EXOK) bad = 1'b1;
        end
        check("exok_stable", 32'(bad), 32'd0);
        in_ack = 1'b1;
        cycles(1);
        in_ack = 1'b0;
        check("exok_ack", 32'(in_cmd), 32'(IC_NONE));
        align_frame();
        keys[14] = 1'b1;
        cycles(20);
        keys[14] = 1'b0;
        cycles(20);
        keys[14] = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycles(1);
            if (in_cmd !== IC_NONE) bad = 1'b1;
        end
        check("exlp_blocked", 32'(bad), 32'd0);
        keys[14] = 1'b0;
        cycles(40);
        keys[14] = 1'b1;
        cycles(39);
        check("exlp_early", 32'(in_cmd), 32'(IC_NONE));
        cycles(1);
        check("exlp", 32'(in_cmd), 32'(IC_EXLP));
        ack_and_release("exlp_ack");

        // Asynchronous reset while holding EXRP
        align_frame();
        keys[18] = 1'b1;
        cycles(46);
        check("exrp_hold", 32'(in_cmd), 32'(IC_EXRP));
        check("exrp_col", 32'(kp_col), 32'h1D);
        Reset = 1'b0;
        #1;
        check("rst_async_cmd", 32'(in_cmd), 32'(IC_NONE));
        check("rst_async_col", 32'(kp_col), 32'h1E);
        keys = '0;
        @(negedge Clock);
        Reset = 1'b1;
        align_frame();
        keys[18] = 1'b1;
        cycles(39);
        check("exrp2_early", 32'(in_cmd), 32'(IC_NONE));
        cycles(1);
        check("exrp2", 32'(in_cmd), 32'(IC_EXRP));
        ack_and_release("exrp2_ack");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_input.md
Name: keypad_input

Overview:
- Upstream producer of the calculator's input interface. Scans a 4x5 active-low key matrix, synchronises and debounces it, and encodes one key into an input-interface command code on in_cmd.
- Holds that code until the controller pulses in_ack, then returns in_cmd to IC_NONE.
- No auto-repeat: the key must be released and debounced before another press is accepted.

Parameters:
- IC_N, input-interface code width (from the input-interface definitions), width of in_cmd.
- SCAN_DIV, 64, clock cycles each column is driven; minimum 4.
- DEB_FRAMES, 4, consecutive identical full scan frames required to accept a press or a release; minimum 1.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-low.
- kp_row  input  4  matrix row sense, active-low, externally pulled up, asynchronous to Clock.
- kp_col  output  5  column drive, active-low; exactly one bit low at all times.
- in_cmd  output  IC_N  command to controller; IC_NONE when idle.
- in_ack  input  1  controller acknowledge, sampled on the rising edge of Clock.

Behaviour:
- Reset values: kp_col=5'b11110 (column 0), in_cmd=IC_NONE, state SCAN, all counters 0, frame capture empty.
- Reset mid-operation drops any pending or held key immediately.
- Synchroniser: kp_row passes through 2 flops before any use.
- Column slot: column c is driven low for SCAN_DIV cycles, order 0,1,2,3,4,0,...
  - The synchronised rows are sampled on the last cycle of the slot.
  - A frame is the 5 slots, COLS*SCAN_DIV cycles in total.
  - Scanning runs continuously in every state.
- Frame result, evaluated at the end of slot 4:
  - NONE if no row is low in any slot.
  - KEY(r,c) if exactly one (row,col) is low.
  - MULTI if more than one is low. MULTI is treated as NONE for acceptance and as "not released" for WAIT_REL.
- Key map (row: col0..col4):
  - r0: IC_NUM7, IC_NUM8, IC_NUM9, IC_EXDI, IC_CLBK
  - r1: IC_NUM4, IC_NUM5, IC_NUM6, IC_EXMU, IC_CLCL
  - r2: IC_NUM1, IC_NUM2, IC_NUM3, IC_EXSB, IC_EXLP
  - r3: IC_NUM0, IC_EXOK, IC_EXAD, IC_EXRP, unused
  - The unused position counts as NONE.
- FSM states: SCAN, DEBOUNCE, HOLD, WAIT_REL.
- SCAN: on frame KEY(k), latch cand=k, deb_cnt=1. If DEB_FRAMES=1 go directly to HOLD, otherwise go to DEBOUNCE.
- DEBOUNCE, per frame:
  - KEY(cand): deb_cnt+1. On reaching DEB_FRAMES go to HOLD.
  - Any other result (different key, NONE, MULTI): go to SCAN with deb_cnt=0; no code is emitted.
- HOLD:
  - in_cmd=code(cand), registered, valid from the cycle after entry.
  - Stays until in_ack=1 is sampled. The next cycle in_cmd=IC_NONE and the state is WAIT_REL.
  - Releasing or changing the key during HOLD has no effect.
- WAIT_REL: requires DEB_FRAMES consecutive NONE frames, then goes to SCAN. Any KEY or MULTI frame resets the release count.
- in_ack outside HOLD is ignored. in_ack held high continuously acknowledges each code after its first valid cycle, so every code is visible for at least 1 cycle.
- Press latency: in_cmd becomes valid 1 cycle after the end of the DEB_FRAMES-th matching frame; the 2-cycle synchroniser delay is included in the sampling.
- Counter widths: slot counter ceil(log2(SCAN_DIV)); deb/release counters ceil(log2(DEB_FRAMES+1)). Counters do not wrap past their terminal values.
- in_cmd changes only on Clock edges; never glitches.

Test Plan:
- Reset with kp_row=4'hF -> kp_col=5'b11110, in_cmd=IC_NONE; column walks 11110, 11101, 11011, 10111, 01111 at SCAN_DIV=4 cycles each.
- SCAN_DIV=4, DEB_FRAMES=2; hold row2 low while col1 is driven, steady -> in_cmd=IC_NUM2 after 2 frames (40 cycles + 1). Pulse in_ack 1 cycle -> IC_NONE next cycle. Keep key held 10 frames -> no second code.
- Bounce: key r0c4 present 1 frame, absent 1 frame, present 2 frames -> exactly one IC_CLBK, emitted after the final 2 frames.
- Two keys pressed together (r1c0, r1c1) -> no code emitted. Release r1c1, keep r1c0 -> IC_NUM4.
- in_ack held at 0 for 100 cycles while key released -> IC_EXOK (r3c1) stays stable; ack -> IC_NONE. New key r2c4 accepted only after 2 NONE frames -> IC_EXLP.
- Reset asserted during HOLD with IC_EXRP (r3c3) showing -> in_cmd=IC_NONE and kp_col=5'b11110 immediately (asynchronous); press r3c3 after release -> IC_EXRP re-emitted normally.
